seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
Parametrised iterative shift-and-add multiplier that produces a full-width 2*WIDTH product, unsigned or two's-complement signed. It processes one multiplier bit per cycle, with optional early termination. Valid/ready handshakes sit on both input and output. It serves as the multi-cycle MUL unit behind the execute stage, with a flush input for pipeline squash.

Parameters:
WIDTH, 8, operand width in bits (legal 2..64); product is 2*WIDTH bits
EARLY_TERM, 1, 1 = finish as soon as remaining multiplier bits are zero; 0 = fixed WIDTH-cycle latency

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash; discards any operation in flight
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = treat a, b as two's complement
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result, unsigned or two's complement per is_signed latched at accept

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE
  - in_ready=1, out_valid=0, product=0
  - internal accumulator, operand and count registers=0
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - Accept when in_valid && in_ready.
  - Latch ma = |a| zero-extended to 2*WIDTH and mb = |b| (WIDTH bits).
  - Magnitudes are taken only when is_signed and the operand is negative; otherwise the raw value is used.
  - Latch neg = is_signed && (a[MSB] ^ b[MSB]); clear acc and cnt; go BUSY.
- Magnitude arithmetic: |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits; no special case.
- BUSY, each cycle:
  - If mb[0], acc += ma (2*WIDTH wide, no overflow possible).
  - Then ma <<= 1, mb >>= 1, cnt++.
  - Finish when cnt==WIDTH-1, or when EARLY_TERM && mb[WIDTH-1:1]==0 (checked before the shift).
  - On finish, register product = neg ? -acc_next : acc_next and go DONE.
- Latency, measured from the accept edge to out_valid high:
  - WIDTH cycles when EARLY_TERM=0.
  - With EARLY_TERM=1: (index of highest set bit of |b|)+1, minimum 1 (b==0 yields 1 cycle, product 0).
- DONE:
  - product and out_valid hold stable until out_ready is sampled high.
  - On out_ready go IDLE. No new accept occurs in the same cycle (in_ready=0 in DONE); the next accept is possible one cycle later.
- flush:
  - Overrides everything: next state IDLE, out_valid drops next cycle, product unchanged.
  - flush && in_valid in IDLE: operands are NOT accepted.
  - flush in DONE discards the unread product.
- Mid-operation reset: immediate return to reset values; no partial product is emitted.
- in_valid while BUSY/DONE is ignored; the producer must hold its operands.
- a, b and is_signed are sampled only at accept; later changes have no effect.

Test Plan:
- Unsigned, WIDTH=8, EARLY_TERM=0: a=15, b=15 -> product=0x00E1, out_valid exactly 8 cycles after accept. Also a=255, b=255 -> 0xFE01.
- Signed: a=-128 (0x80), b=-128 -> 0x4000. Also a=-3, b=5 -> 0xFFF1. Also a=0x80 with is_signed=0, b=2 -> 0x0100.
- EARLY_TERM=1: b=0, a=0xAB -> product 0, latency 1. b=1, a=0x7F -> 0x007F, latency 1. b=0x40 -> latency 7.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> product and out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, and back-to-back ops return correct results.
- flush asserted 3 cycles into BUSY -> no out_valid, in_ready=1 next cycle. The following op 6*7 returns 42. flush with in_valid in IDLE -> no accept.
- rst_n pulsed low mid-BUSY, asynchronous to clk -> outputs at reset values immediately, no product emitted after release.

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one multiplier bit per cycle, 2*WIDTH product,
// unsigned or two's-complement, valid/ready on both sides, flush for pipeline squash.
module seq_shift_add_multiplier #(
    parameter int WIDTH      = 8,
    parameter int EARLY_TERM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_d;

    logic [2*WIDTH-1:0] ma, acc, acc_next, prod_next;
    logic [WIDTH-1:0]   mb, mag_a, mag_b;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               accept, finish;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

    // Work on magnitudes; |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit value.
    assign mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign acc_next  = mb[0] ? (acc + ma) : acc;
    assign prod_next = neg ? (~acc_next + 1'b1) : acc_next;
    // Early exit looks at the bits still to come, before this cycle's shift.
    assign finish    = (cnt == CW'(WIDTH - 1)) ||
                       ((EARLY_TERM != 0) && (mb[WIDTH-1:1] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (finish)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            ma  <= {{WIDTH{1'b0}}, mag_a};
            mb  <= mag_b;
            neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY && !flush) begin
            acc <= acc_next;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt + 1'b1;
            if (finish) product <= prod_next;
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: fixed-latency (u0) and early-terminating (u1)
// instances, table-driven products/latencies plus backpressure, flush and reset sequences.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        is_signed = 1'b0;
    logic [1:0]  iv = '0, ordy = '0, ir, ov;
    logic [15:0] prod [2];

    int passed = 0, total = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(8), .EARLY_TERM(0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(ov[0]), .out_ready(ordy[0]),
        .product(prod[0]));

    seq_shift_add_multiplier #(.WIDTH(8), .EARLY_TERM(1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(ov[1]), .out_ready(ordy[1]),
        .product(prod[1]));

    typedef struct {
        int          sel;
        logic [7:0]  a, b;
        logic        s;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one op, measure accept-to-out_valid cycles, check product, then drain it.
    task automatic run_op(input int sel, input logic [7:0] va, input logic [7:0] vb,
                          input logic s, input logic [15:0] exp, input int lat,
                          input string name);
        int n;
        @(negedge clk);
        check({name, ".in_ready"}, ir[sel], 1);
        a = va; b = vb; is_signed = s; iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        a = 8'h5A; b = 8'hC3; is_signed = ~s;   // post-accept changes must not matter
        n = 0;
        while (!ov[sel] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, ".latency"}, n, lat);
        check({name, ".product"}, prod[sel], exp);
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        check({name, ".idle_after"}, {ir[sel], ov[sel]}, 2'b10);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{0, 8'd15,  8'd15,  1'b0, 16'h00E1, 8};
        vecs[1]  = '{0, 8'hFF,  8'hFF,  1'b0, 16'hFE01, 8};
        vecs[2]  = '{0, 8'h80,  8'h80,  1'b1, 16'h4000, 8};
        vecs[3]  = '{0, 8'hFD,  8'd5,   1'b1, 16'hFFF1, 8};
        vecs[4]  = '{0, 8'h80,  8'd2,   1'b0, 16'h0100, 8};
        vecs[5]  = '{1, 8'hAB,  8'd0,   1'b0, 16'h0000, 1};
        vecs[6]  = '{1, 8'h7F,  8'd1,   1'b0, 16'h007F, 1};
        vecs[7]  = '{1, 8'd3,   8'h40,  1'b0, 16'h00C0, 7};
        vecs[8]  = '{1, 8'hFD,  8'd5,   1'b1, 16'hFFF1, 3};
        vecs[9]  = '{1, 8'd7,   8'hFF,  1'b1, 16'hFFF9, 1};
        vecs[10] = '{1, 8'h80,  8'h80,  1'b1, 16'h4000, 8};
        vecs[11] = '{1, 8'h12,  8'h34,  1'b0, 16'h03A8, 6};

        #3;
        check("reset.u0", {ir[0], ov[0], prod[0]}, {2'b10, 16'h0});
        check("reset.u1", {ir[1], ov[1], prod[1]}, {2'b10, 16'h0});
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));

        // Backpressure: DONE holds for 5 cycles, then back-to-back ops.
        @(negedge clk);
        a = 8'd9; b = 8'd11; is_signed = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1; iv[0] = 1'b0;
        seen = 0;
        while (!ov[0] && seen < 40) begin @(posedge clk); #1; seen++; end
        check("bp.latency", seen, 8);
        iv[0] = 1'b1;   // must be ignored while DONE
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp.hold%0d", k), {ov[0], ir[0], prod[0]}, {2'b10, 16'h0063});
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1; ordy[0] = 1'b0;
        check("bp.release", {ir[0], ov[0]}, 2'b10);
        run_op(0, 8'd13, 8'd17, 1'b0, 16'd221, 8, "b2b0");
        run_op(0, 8'hFF, 8'd2, 1'b1, 16'hFFFE, 8, "b2b1");

        // Flush three cycles into BUSY.
        @(negedge clk);
        a = 8'd200; b = 8'd100; iv[0] = 1'b1;
        @(posedge clk); #1; iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush.state", {ir[0], ov[0]}, 2'b10);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (ov[0]) seen++; end
        check("flush.no_out", seen, 0);
        run_op(0, 8'd6, 8'd7, 1'b0, 16'd42, 8, "after_flush");

        // Flush with in_valid in IDLE: no accept.
        @(negedge clk);
        a = 8'd3; b = 8'd3; iv[0] = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0; flush = 1'b0;
        check("flush_idle.in_ready", ir[0], 1);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (ov[0]) seen++; end
        check("flush_idle.no_out", seen, 0);

        // Asynchronous reset mid-BUSY.
        @(negedge clk);
        a = 8'd9; b = 8'd9; iv[0] = 1'b1;
        @(posedge clk); #1; iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst.outputs", {ir[0], ov[0], prod[0]}, {2'b10, 16'h0});
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (ov[0]) seen++; end
        check("rst.no_out", seen, 0);
        check("rst.product", prod[0], 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
